rom_rd_arbiter: RTL

ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

---
 rtl/rom_arb_pkg.sv | 14 +
 rtl/rom_4x4_async.sv | 23 ++
 rtl/rom_rd_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the two-requester ROM read arbiter.
// Holds the FSM state encoding so the top level and any tooling agree on it.
package rom_arb_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/rom_4x4_async.sv
// Four-entry combinational ROM; data_out follows address with no clock.
// Latency: zero cycles. Backpressure: none, purely combinational.
// Entries above index 3 read as zero when ADDR_W is widened.
module rom_4x4_async #(
    parameter int ADDR_W = rom_arb_pkg::ADDR_W,
    parameter int DATA_W = rom_arb_pkg::DATA_W
) (
    output logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] address
);

    always_comb begin
        data_out = '0;
        case (int'(address))
            0:       data_out = DATA_W'(4'h3);
            1:       data_out = DATA_W'(4'hC);
            2:       data_out = DATA_W'(4'h5);
            3:       data_out = DATA_W'(4'hA);
            default: data_out = '0;
        endcase
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Arbitrates two read requesters onto one async ROM; one read in flight at a time.
// Latency: gnt the edge after req is sampled, rd_valid/rd_data one edge later.
// Backpressure: req ignored while busy; a requester drops req on gnt. ROM_RD_ARBITER_RR_EN selects round-robin.
module rom_rd_arbiter #(
    parameter int ADDR_W = rom_arb_pkg::ADDR_W,
    parameter int DATA_W = rom_arb_pkg::DATA_W,
    parameter int CNT_W  = rom_arb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_cnt
);

    import rom_arb_pkg::*;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                owner;
    logic                win;
    logic [DATA_W-1:0]   rom_dat;

`ifdef ROM_RD_ARBITER_RR_EN
    logic                rr_ptr;

    // Pointer only matters under contention; a lone requester always wins.
    always_comb win = (req == 2'b11) ? rr_ptr : req[1];
`else
    always_comb win = ~req[0];
`endif

    rom_4x4_async #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .data_out (rom_dat),
        .address  (addr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            owner    <= 1'b0;
            gnt      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            rd_cnt   <= '0;
`ifdef ROM_RD_ARBITER_RR_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            gnt      <= '0;
            rd_valid <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= READ;
                        busy       <= 1'b1;
                        owner      <= win;
                        addr_q     <= win ? addr1 : addr0;
                        gnt[win]   <= 1'b1;
`ifdef ROM_RD_ARBITER_RR_EN
                        rr_ptr     <= ~win;
`endif
                    end
                end
                READ: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    rd_data         <= rom_dat;
                    rd_valid[owner] <= 1'b1;
                    if (rd_cnt != {CNT_W{1'b1}})
                        rd_cnt <= rd_cnt + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
